// File: rtl/unidad_control.sv
// unidad_control: fetch/decode/execute sequencer for the 4-bit Von Neumann
// processor. Drives a shared synchronous memory and the downstream ALU.
// Ports: clk, rst (async, active high); mem_addr/mem_rdata/mem_wdata/mem_we
// to the shared memory; alu_a/alu_b/alu_cs to the ALU, alu_op/alu_flags
// back from it; pc, acc, halted for observation.
// Optional: `define SINGLE_STEP_EN adds input step; FETCH then waits for it.
module unidad_control #(
   parameter logic [3:0] RESET_PC = 4'h0
) (
   input  logic       clk,
   input  logic       rst,
`ifdef SINGLE_STEP_EN
   input  logic       step,
`endif
   output logic [3:0] mem_addr,
   input  logic [7:0] mem_rdata,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [4:0] alu_cs,
   input  logic [3:0] alu_op,
   input  logic [3:0] alu_flags,
   output logic [3:0] pc,
   output logic [3:0] acc,
   output logic       halted
);

   typedef enum logic [3:0] {
      FETCH, DECODE, READ, EXEC, ALU_WAIT,
      CAPTURE, FLAGS, STORE, HALT
   } state_t;

   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_NOT = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_LDA = 4'h7;
   localparam logic [3:0] OP_STA = 4'h8;
   localparam logic [3:0] OP_JMP = 4'h9;
   localparam logic [3:0] OP_JZ  = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t     state, state_n;
   logic [3:0] pc_n, acc_n, a_n, b_n;
   logic [7:0] ir, ir_n;
   logic [4:0] cs_n;
   logic       z, z_n, c, c_n;
   logic [3:0] opc_d, opc;

   // V and S flags are not kept by this sequencer
   logic unused_flags;
   assign unused_flags = ^{alu_flags[3], alu_flags[1]};

   // DECODE must look at the word arriving from memory, not the stale ir
   assign opc_d = mem_rdata[7:4];
   assign opc   = ir[7:4];

   assign mem_addr  = (state == READ || state == STORE) ? ir[3:0] : pc;
   assign mem_wdata = {4'b0, acc};
   assign mem_we    = (state == STORE);
   assign halted    = (state == HALT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= FETCH;
         pc     <= RESET_PC;
         ir     <= 8'h00;
         acc    <= 4'h0;
         z      <= 1'b0;
         c      <= 1'b0;
         alu_a  <= 4'h0;
         alu_b  <= 4'h0;
         alu_cs <= 5'd0;
      end else begin
         state  <= state_n;
         pc     <= pc_n;
         ir     <= ir_n;
         acc    <= acc_n;
         z      <= z_n;
         c      <= c_n;
         alu_a  <= a_n;
         alu_b  <= b_n;
         alu_cs <= cs_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      ir_n    = ir;
      acc_n   = acc;
      z_n     = z;
      c_n     = c;
      a_n     = alu_a;
      b_n     = alu_b;
      // cs only ever leaves EXEC nonzero, so the ALU sees it for one cycle
      cs_n    = 5'd0;
      unique case (state)
         FETCH: begin
`ifdef SINGLE_STEP_EN
            if (step) state_n = DECODE;
`else
            state_n = DECODE;
`endif
         end
         DECODE: begin
            ir_n    = mem_rdata;
            pc_n    = pc + 4'h1;
            state_n = FETCH;
            case (opc_d)
               OP_JMP: pc_n = mem_rdata[3:0];
               OP_JZ:  if (z) pc_n = mem_rdata[3:0];
               OP_HLT: state_n = HALT;
               OP_STA: state_n = STORE;
               OP_NOT: state_n = EXEC;
               OP_ADD, OP_SUB, OP_AND, OP_OR,
               OP_XOR, OP_LDA: state_n = READ;
               default: state_n = FETCH;
            endcase
         end
         READ: state_n = EXEC;
         EXEC: begin
            a_n     = (opc == OP_LDA) ? mem_rdata[3:0] : acc;
            b_n     = (opc == OP_NOT) ? 4'h0 : mem_rdata[3:0];
            // opcodes 1..7 map directly onto ALU select codes 1..7
            cs_n    = {1'b0, opc};
            state_n = ALU_WAIT;
         end
         ALU_WAIT: state_n = CAPTURE;
         CAPTURE: begin
            acc_n   = alu_op;
            state_n = FLAGS;
         end
         FLAGS: begin
            // flags trail the result by one clock, so sample here only
            z_n     = alu_flags[2];
            c_n     = alu_flags[0];
            state_n = FETCH;
         end
         STORE: state_n = FETCH;
         HALT:  state_n = HALT;
         default: state_n = FETCH;
      endcase
   end

endmodule
